// File: rtl/uart_pkt_router.sv
// ---------------------------------------------------------------------------
// uart_pkt_router
//
// Packet decoder between the UART byte receiver and the DC channel register
// banks / launch register bank. Received bytes are packed MSB-first into
// 32-bit words. The first word of a packet is a header that selects either
// one DC channel or the launch bank. The following payload words are issued
// as single-cycle register writes with a word index address.
//
// Malformed headers and inter-byte timeouts raise a one-cycle o_err pulse
// and return the decoder to header hunting.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_byte        received byte
//   i_byte_valid  one-cycle strobe qualifying i_byte
//   o_wr_en       one-cycle register write strobe
//   o_wr_sel      one-hot DC channel select (zero on launch writes)
//   o_wr_launch   write targets the launch bank
//   o_wr_addr     payload word index within the packet
//   o_wr_data     payload word
//   o_pkt_done    strobe concurrent with the last payload write
//   o_err         strobe on bad header or inter-byte timeout
//   o_busy        packet or partial word in progress
// ---------------------------------------------------------------------------
module uart_pkt_router #(
  parameter int NUM_CHANNEL    = 4,
  parameter int TOTAL_REGS     = 8,
  parameter int LAUNCH_REGS    = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_byte,
  input  logic                   i_byte_valid,
  output logic                   o_wr_en,
  output logic [NUM_CHANNEL-1:0] o_wr_sel,
  output logic                   o_wr_launch,
  output logic [ADDR_WIDTH-1:0]  o_wr_addr,
  output logic [31:0]            o_wr_data,
  output logic                   o_pkt_done,
  output logic                   o_err,
  output logic                   o_busy
);

  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  // Bits of the header that carry the channel field; all other bits must be 1.
  function automatic logic [31:0] chan_field_mask();
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 8; i < 8 + NUM_CHANNEL; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [31:0] CHAN_FIELD_MASK = chan_field_mask();

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_CHANNEL-1:0] v);
    return (v != '0) && ((v & (v - NUM_CHANNEL'(1))) == '0);
  endfunction

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_CHAN   = 2'd1,
    ST_LAUNCH = 2'd2
  } state_t;

  state_t                 state;
  logic [1:0]             byte_cnt;
  logic [23:0]            shift;
  logic [ADDR_WIDTH-1:0]  word_cnt;
  logic [NUM_CHANNEL-1:0] chan_sel;
  logic [TIMER_WIDTH-1:0] timer;

  logic [31:0]            word;
  logic                   word_done;
  logic [NUM_CHANNEL-1:0] hdr_zero;
  logic                   hdr_is_launch;
  logic                   hdr_is_chan;
  logic                   last_word;
  logic                   timeout_hit;

  // Word assembly, header classification and timeout detection.
  always_comb begin
    word          = {shift, i_byte};
    word_done     = i_byte_valid && (byte_cnt == 2'd3);
    // The single cleared bit in the channel field becomes the one-hot select.
    hdr_zero      = ~word[8 +: NUM_CHANNEL];
    hdr_is_launch = (word == 32'hFFFF_FFFF);
    hdr_is_chan   = ((word | CHAN_FIELD_MASK) == 32'hFFFF_FFFF) && is_onehot(hdr_zero);
    last_word     = (state == ST_CHAN) ? (word_cnt == ADDR_WIDTH'(TOTAL_REGS - 1))
                                       : (word_cnt == ADDR_WIDTH'(LAUNCH_REGS - 1));
    // A byte on the expiry cycle takes priority over the timeout.
    timeout_hit   = o_busy && !i_byte_valid &&
                    (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
  end

  // Packet FSM, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_HDR;
      byte_cnt    <= 2'd0;
      shift       <= 24'h00_0000;
      word_cnt    <= '0;
      chan_sel    <= '0;
      timer       <= '0;
      o_wr_en     <= 1'b0;
      o_wr_sel    <= '0;
      o_wr_launch <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= 32'h0000_0000;
      o_pkt_done  <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_wr_en     <= 1'b0;
      o_wr_sel    <= '0;
      o_wr_launch <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= 32'h0000_0000;
      o_pkt_done  <= 1'b0;
      o_err       <= 1'b0;

      if (i_byte_valid) begin
        timer    <= '0;
        shift    <= word[23:0];
        byte_cnt <= byte_cnt + 2'd1;
        if (word_done) begin
          case (state)
            ST_HDR: begin
              word_cnt <= '0;
              if (hdr_is_launch) begin
                state  <= ST_LAUNCH;
                o_busy <= 1'b1;
              end else if (hdr_is_chan) begin
                state    <= ST_CHAN;
                chan_sel <= hdr_zero;
                o_busy   <= 1'b1;
              end else begin
                // No bit-level realignment: the next 4 bytes form the next header.
                state  <= ST_HDR;
                o_err  <= 1'b1;
                o_busy <= 1'b0;
              end
            end
            ST_CHAN, ST_LAUNCH: begin
              o_wr_en     <= 1'b1;
              o_wr_sel    <= (state == ST_CHAN) ? chan_sel : '0;
              o_wr_launch <= (state == ST_LAUNCH);
              o_wr_addr   <= word_cnt;
              o_wr_data   <= word;
              if (last_word) begin
                o_pkt_done <= 1'b1;
                state      <= ST_HDR;
                word_cnt   <= '0;
                o_busy     <= 1'b0;
              end else begin
                word_cnt <= word_cnt + ADDR_WIDTH'(1);
                o_busy   <= 1'b1;
              end
            end
            default: begin
              state    <= ST_HDR;
              word_cnt <= '0;
              o_busy   <= 1'b0;
            end
          endcase
        end else begin
          // A partial word is pending.
          o_busy <= 1'b1;
        end
      end else if (timeout_hit) begin
        o_err    <= 1'b1;
        state    <= ST_HDR;
        byte_cnt <= 2'd0;
        word_cnt <= '0;
        timer    <= '0;
        o_busy   <= 1'b0;
      end else if (o_busy) begin
        timer <= timer + TIMER_WIDTH'(1);
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_router.sv
module tb_uart_pkt_router;

  localparam int NC = 4;
  localparam int TR = 8;
  localparam int LR = 4;
  localparam int AW = 4;
  localparam int TO = 16384;

  logic          i_clk;
  logic          i_rst;
  logic [7:0]    i_byte;
  logic          i_byte_valid;
  logic          o_wr_en;
  logic [NC-1:0] o_wr_sel;
  logic          o_wr_launch;
  logic [AW-1:0] o_wr_addr;
  logic [31:0]   o_wr_data;
  logic          o_pkt_done;
  logic          o_err;
  logic          o_busy;

  uart_pkt_router #(
    .NUM_CHANNEL(NC), .TOTAL_REGS(TR), .LAUNCH_REGS(LR),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_wr_en(o_wr_en), .o_wr_sel(o_wr_sel), .o_wr_launch(o_wr_launch),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_pkt_done(o_pkt_done),
    .o_err(o_err), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected outputs for the cycle after the next rising edge
  logic          exp_wr_en, exp_launch, exp_done, exp_err, exp_busy;
  logic [NC-1:0] exp_sel;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_data;

  // packet model: 0 = waiting for header, 1 = channel payload, 2 = launch payload
  int          m_mode, m_nb, m_idx, m_chan, m_silent;
  logic [31:0] m_word;

  // observations of the DUT outputs
  int            dut_wr, dut_err, dut_done;
  logic [AW-1:0] last_addr, done_addr;
  logic [31:0]   last_data;
  logic [NC-1:0] last_sel;
  logic          last_launch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // channel index for a valid channel header, -1 otherwise
  function automatic int hdr_chan(input logic [31:0] w);
    int zeros;
    int pos;
    zeros = 0;
    pos = -1;
    for (int i = 0; i < 32; i++) begin
      if (w[i] == 1'b0) begin
        zeros++;
        pos = i;
      end
    end
    if (zeros == 1 && pos >= 8 && pos < 8 + NC) return pos - 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_nb = 0; m_idx = 0; m_chan = 0; m_silent = 0; m_word = 32'h0;
    exp_wr_en = 1'b0; exp_launch = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_busy = 1'b0; exp_sel = '0; exp_addr = '0; exp_data = 32'h0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    logic [NC-1:0] one;
    int c;
    one = 1;
    exp_wr_en = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    if (v) begin
      m_silent = 0;
      m_word = {m_word[23:0], b};
      m_nb++;
      if (m_nb == 4) begin
        m_nb = 0;
        if (m_mode == 0) begin
          c = hdr_chan(m_word);
          if (m_word == 32'hFFFF_FFFF) begin
            m_mode = 2; m_idx = 0;
          end else if (c >= 0) begin
            m_mode = 1; m_chan = c; m_idx = 0;
          end else begin
            exp_err = 1'b1;
          end
        end else begin
          exp_wr_en  = 1'b1;
          exp_sel    = (m_mode == 1) ? (one << m_chan) : '0;
          exp_launch = (m_mode == 2);
          exp_addr   = AW'(m_idx);
          exp_data   = m_word;
          m_idx++;
          if (m_idx == ((m_mode == 1) ? TR : LR)) begin
            exp_done = 1'b1;
            m_mode = 0;
            m_idx = 0;
          end
        end
      end
    end else if (m_mode != 0 || m_nb != 0) begin
      m_silent++;
      if (m_silent == TO) begin
        exp_err = 1'b1;
        m_mode = 0; m_nb = 0; m_idx = 0; m_silent = 0;
      end
    end else begin
      m_silent = 0;
    end
    exp_busy = (m_mode != 0) || (m_nb != 0);
  endtask

  // per-cycle comparison against the model, just after each rising edge
  always @(posedge i_clk) begin
    #1;
    chk("wr_en", o_wr_en, exp_wr_en);
    chk("pkt_done", o_pkt_done, exp_done);
    chk("err", o_err, exp_err);
    chk("busy", o_busy, exp_busy);
    if (exp_wr_en) begin
      chk("wr_sel", o_wr_sel, exp_sel);
      chk("wr_launch", o_wr_launch, exp_launch);
      chk("wr_addr", o_wr_addr, exp_addr);
      chk("wr_data", o_wr_data, exp_data);
    end
    if (o_wr_en) begin
      dut_wr++;
      last_addr = o_wr_addr; last_data = o_wr_data;
      last_sel = o_wr_sel; last_launch = o_wr_launch;
    end
    if (o_pkt_done) begin
      dut_done++;
      done_addr = o_wr_addr;
    end
    if (o_err) dut_err++;
  end

  task automatic cycle(input logic v, input logic [7:0] b);
    @(negedge i_clk);
    i_byte_valid = v;
    i_byte = b;
    model_step(v, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, w[31-8*i -: 8]);
      idle(gap);
    end
  endtask

  task automatic send_chan_pkt(input int k, input logic [31:0] base, input int gap);
    send_word(32'hFFFF_FFFF & ~(32'h0000_0001 << (8 + k)), gap);
    for (int i = 0; i < TR; i++) send_word(base + 32'(i), gap);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, o_wr_en, 32'h0);
    chk({tag, "_wr_sel"}, o_wr_sel, 32'h0);
    chk({tag, "_wr_launch"}, o_wr_launch, 32'h0);
    chk({tag, "_wr_addr"}, o_wr_addr, 32'h0);
    chk({tag, "_wr_data"}, o_wr_data, 32'h0);
    chk({tag, "_pkt_done"}, o_pkt_done, 32'h0);
    chk({tag, "_err"}, o_err, 32'h0);
    chk({tag, "_busy"}, o_busy, 32'h0);
  endtask

  int w0, e0, d0;

  task automatic snap();
    w0 = dut_wr; e0 = dut_err; d0 = dut_done;
  endtask

  initial begin
    dut_wr = 0; dut_err = 0; dut_done = 0;
    last_addr = '0; done_addr = '0; last_data = 32'h0; last_sel = '0; last_launch = 1'b0;
    i_rst = 1'b1; i_byte_valid = 1'b0; i_byte = 8'h00;
    model_reset();
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    model_step(1'b0, 8'h00);

    // channel 2 packet with gaps between bytes
    snap();
    send_chan_pkt(2, 32'h0000_0001, 2);
    idle(3);
    chk("t1_writes", dut_wr - w0, 8);
    chk("t1_done", dut_done - d0, 1);
    chk("t1_errs", dut_err - e0, 0);
    chk("t1_done_addr", done_addr, 7);
    chk("t1_last_data", last_data, 32'h0000_0008);
    chk("t1_last_sel", last_sel, 4'b0100);
    chk("t1_last_launch", last_launch, 0);
    chk("t1_busy", o_busy, 0);

    // launch packet
    snap();
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_000F, 1);
    send_word(32'h0000_0000, 1);
    send_word(32'h0000_0000, 1);
    send_word(32'hDEAD_BEEF, 1);
    idle(3);
    chk("t2_writes", dut_wr - w0, 4);
    chk("t2_done_addr", done_addr, 3);
    chk("t2_last_data", last_data, 32'hDEAD_BEEF);
    chk("t2_last_sel", last_sel, 0);
    chk("t2_last_launch", last_launch, 1);

    // channel 0 packet then a launch packet with no gap
    snap();
    send_chan_pkt(0, 32'h0000_0100, 0);
    send_word(32'hFFFF_FFFF, 0);
    for (int i = 0; i < LR; i++) send_word(32'h0000_00A0 + 32'(i), 0);
    idle(3);
    chk("t2b_writes", dut_wr - w0, 12);
    chk("t2b_done", dut_done - d0, 2);
    chk("t2b_last_data", last_data, 32'h0000_00A3);

    // bad headers, then a valid channel 1 packet
    snap();
    send_word(32'hFFFF_F3FF, 1);
    send_word(32'h7FFF_FFFF, 1);
    idle(3);
    chk("t3_errs", dut_err - e0, 2);
    chk("t3_writes", dut_wr - w0, 0);
    send_chan_pkt(1, 32'h0000_0200, 0);
    idle(3);
    chk("t3_chan1_writes", dut_wr - w0, 8);
    chk("t3_last_sel", last_sel, 4'b0010);

    // timeout after 2 payload bytes
    snap();
    send_word(32'hFFFF_F7FF, 0);
    cycle(1'b1, 8'h12);
    cycle(1'b1, 8'h34);
    idle(TO + 3);
    chk("t4_errs", dut_err - e0, 1);
    chk("t4_writes", dut_wr - w0, 0);
    chk("t4_busy", o_busy, 0);
    send_chan_pkt(3, 32'h0000_0300, 0);
    idle(3);
    chk("t4_writes_after", dut_wr - w0, 8);
    chk("t4_done_addr", done_addr, 7);
    chk("t4_last_sel", last_sel, 4'b1000);

    // byte arriving on the expiry cycle wins
    snap();
    send_word(32'hFFFF_F7FF, 0);
    cycle(1'b1, 8'hAB);
    cycle(1'b1, 8'hCD);
    idle(TO - 1);
    cycle(1'b1, 8'hEF);
    idle(1);
    chk("t5_errs", dut_err - e0, 0);
    chk("t5_busy", o_busy, 1);
    cycle(1'b1, 8'h01);
    idle(1);
    chk("t5_first_data", last_data, 32'hABCD_EF01);
    for (int i = 1; i < TR; i++) send_word(32'h0000_0500 + 32'(i), 0);
    idle(3);
    chk("t5_writes", dut_wr - w0, 8);
    chk("t5_errs_end", dut_err - e0, 0);

    // reset in the middle of a channel 0 packet
    send_word(32'hFFFF_FEFF, 0);
    for (int i = 0; i < 3; i++) send_word(32'h0000_0600 + 32'(i), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_byte_valid = 1'b0;
    #1;
    check_outputs_zero("midrst");
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    model_step(1'b0, 8'h00);
    snap();
    send_word(32'h0000_0005, 0);
    idle(3);
    chk("t6_writes_no_hdr", dut_wr - w0, 0);
    chk("t6_errs", dut_err - e0, 1);
    send_chan_pkt(0, 32'h0000_0700, 1);
    idle(3);
    chk("t6_writes", dut_wr - w0, 8);
    chk("t6_last_sel", last_sel, 4'b0001);
    chk("t6_last_data", last_data, 32'h0000_0707);

    // back-to-back bytes, payload containing 0xFFFFFFFF
    snap();
    send_chan_pkt(1, 32'hFFFF_FFF8, 0);
    idle(3);
    chk("t7_writes", dut_wr - w0, 8);
    chk("t7_done", dut_done - d0, 1);
    chk("t7_errs", dut_err - e0, 0);
    chk("t7_last_data", last_data, 32'hFFFF_FFFF);
    chk("t7_done_addr", done_addr, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
